fft_ctrl: RTL and testbench

FFT_CTRL -- requirements
Module: fft_ctrl

---
 rtl/fft_ctrl.sv | 150 +++++++++++++++
 tb/tb_fft_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_ctrl.sv
// Sequencer for a 16-point radix-2 in-place FFT around an external butterfly PE.
// Loads samples, runs 4 stages of 8 butterflies, then dumps results in natural order.
module fft_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [3:0]  out_index,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        pe_rst,
    output logic [31:0] pe_a,
    output logic [31:0] pe_b,
    output logic [2:0]  pe_power,
    output logic        pe_ab_valid,
    input  logic [31:0] pe_fft_a,
    input  logic [31:0] pe_fft_b,
    input  logic        pe_valid
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLR, S_FEED, S_COLLECT, S_NEXT, S_DUMP
    } state_t;

    state_t        r_state, w_next;
    logic [31:0]   r_mem [16];
    logic [3:0]    r_cnt;
    logic [1:0]    r_stage;
    logic [TW-1:0] r_tmo;
    logic          r_err, r_done;

    logic [3:0]    w_span, w_j, w_ia, w_ib, w_rev;
    logic [2:0]    w_j3;
    logic          w_timeout, w_last_rslt;

    // Butterfly k = r_cnt[2:0]; (k div span)*2*span equals (k with low span bits cleared) << 1.
    assign w_span      = 4'd8 >> r_stage;
    assign w_j         = {1'b0, r_cnt[2:0]} & (w_span - 4'd1);
    assign w_j3        = w_j[2:0];
    assign w_ia        = (({1'b0, r_cnt[2:0]} & ~(w_span - 4'd1)) << 1) | w_j;
    assign w_ib        = w_ia | w_span;
    assign w_rev       = {r_cnt[0], r_cnt[1], r_cnt[2], r_cnt[3]};
    assign w_timeout   = (r_state == S_COLLECT) && !pe_valid && (r_tmo == TW'(TIMEOUT - 1));
    assign w_last_rslt = (r_state == S_COLLECT) && pe_valid && (r_cnt[2:0] == 3'd7);

    always_comb begin
        w_next      = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_index   = '0;
        busy        = (r_state != S_IDLE);
        done        = r_done;
        err         = r_err;
        pe_rst      = !rst || (r_state == S_CLR);
        pe_a        = '0;
        pe_b        = '0;
        pe_power    = '0;
        pe_ab_valid = 1'b0;
        case (r_state)
            S_IDLE:    if (start) w_next = S_LOAD;
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && r_cnt == 4'd15) w_next = S_CLR;
            end
            S_CLR:     w_next = S_FEED;
            S_FEED: begin
                pe_ab_valid = 1'b1;
                pe_a        = r_mem[w_ia];
                pe_b        = r_mem[w_ib];
                pe_power    = w_j3 << r_stage;
                if (r_cnt[2:0] == 3'd7) w_next = S_COLLECT;
            end
            S_COLLECT: begin
                if (w_timeout)        w_next = S_IDLE;
                else if (w_last_rslt) w_next = S_NEXT;
            end
            S_NEXT:    w_next = (r_stage == 2'd3) ? S_DUMP : S_CLR;
            S_DUMP: begin
                out_valid = 1'b1;
                out_index = r_cnt;
                out_data  = r_mem[w_rev];
                if (r_cnt == 4'd15) w_next = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_stage <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) r_mem[i] <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_err   <= 1'b0;
                    r_stage <= '0;
                    r_cnt   <= '0;
                end
                S_LOAD: if (in_valid) begin
                    r_mem[r_cnt] <= in_data;
                    r_cnt        <= r_cnt + 4'd1;
                end
                S_CLR:  r_cnt <= '0;
                S_FEED: begin
                    r_cnt <= (r_cnt[2:0] == 3'd7) ? 4'd0 : r_cnt + 4'd1;
                    r_tmo <= '0;
                end
                S_COLLECT: begin
                    if (pe_valid) begin
                        r_mem[w_ia] <= pe_fft_a;
                        r_mem[w_ib] <= pe_fft_b;
                        r_cnt       <= w_last_rslt ? 4'd0 : r_cnt + 4'd1;
                        r_tmo       <= '0;
                    end else if (w_timeout) begin
                        r_err  <= 1'b1;
                        r_done <= 1'b1;
                        r_tmo  <= '0;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_NEXT: begin
                    r_stage <= r_stage + 2'd1;
                    r_cnt   <= '0;
                end
                S_DUMP: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_ctrl.sv
// Directed/randomised bench for fft_ctrl: the bench plays the butterfly PE and
// predicts the in-place transform schedule from a pair-list model of each stage.
module tb_fft_ctrl;
    localparam int unsigned TMO = 20;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, pe_valid;
    logic [31:0] in_data, pe_fft_a, pe_fft_b;
    logic        in_ready, out_valid, busy, done, err, pe_rst, pe_ab_valid;
    logic [31:0] out_data, pe_a, pe_b;
    logic [3:0]  out_index;
    logic [2:0]  pe_power;

    fft_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
        .busy(busy), .done(done), .err(err), .pe_rst(pe_rst), .pe_a(pe_a), .pe_b(pe_b),
        .pe_power(pe_power), .pe_ab_valid(pe_ab_valid), .pe_fft_a(pe_fft_a),
        .pe_fft_b(pe_fft_b), .pe_valid(pe_valid)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] ref_mem [16];
    int          pe_rst_pulses;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pe_fa(input bit mix, input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] p);
        return mix ? (a + b + {29'd0, p}) : a;
    endfunction

    function automatic logic [31:0] pe_fb(input bit mix, input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] p);
        return mix ? ((a - b) ^ {p, 29'd0}) : b;
    endfunction

    function automatic int bitrev(input int i);
        int r = 0;
        for (int b = 0; b < 4; b++) if (i & (1 << b)) r |= 1 << (3 - b);
        return r;
    endfunction

    // mode 0: full run, 1: PE silent in stage 1 (timeout), 2: reset during stage-2 COLLECT
    task automatic run(input int lat, input bit gaps, input bit mix, input bit noise, input int mode);
        int          ia_l [8];
        int          ib_l [8];
        logic [2:0]  pw_l [8];
        logic [31:0] ra [8];
        logic [31:0] rb [8];
        int          n, half;
        for (int i = 0; i < 16; i++) ref_mem[i] = mix ? $urandom : 32'(i);
        pe_rst_pulses = 0;

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("start_err_clear", err, 0);
        chk("start_busy", busy, 1);
        chk("load_in_ready", in_ready, 1);

        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                if (noise) start = 1'($urandom);
                @(negedge clk);
                chk("load_gap_ready", in_ready, 1);
            end
            in_valid = 1'b1;
            in_data  = ref_mem[i];
            if (noise) start = 1'($urandom);
            @(negedge clk);
            in_valid = 1'b0;
        end
        start = 1'b0;
        chk("load_done_ready", in_ready, 0);

        for (int s = 0; s < 4; s++) begin
            chk("clr_pe_rst", pe_rst, 1);
            chk("clr_ab_valid", pe_ab_valid, 0);
            if (pe_rst === 1'b1) pe_rst_pulses++;
            n    = 0;
            half = 8 >> s;
            for (int blk = 0; blk < 16; blk += 2 * half)
                for (int j = 0; j < half; j++) begin
                    ia_l[n] = blk + j;
                    ib_l[n] = blk + j + half;
                    pw_l[n] = 3'((j << s) & 7);
                    n++;
                end
            if (noise) begin
                pe_valid = 1'b1;
                pe_fft_a = $urandom;
                pe_fft_b = $urandom;
            end
            @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                chk("feed_ab_valid", pe_ab_valid, 1);
                chk("feed_pe_rst", pe_rst, 0);
                chk($sformatf("feed_a_s%0d_k%0d", s, k), pe_a, ref_mem[ia_l[k]]);
                chk($sformatf("feed_b_s%0d_k%0d", s, k), pe_b, ref_mem[ib_l[k]]);
                chk($sformatf("feed_pw_s%0d_k%0d", s, k), 32'(pe_power), 32'(pw_l[k]));
                ra[k] = pe_fa(mix, ref_mem[ia_l[k]], ref_mem[ib_l[k]], pw_l[k]);
                rb[k] = pe_fb(mix, ref_mem[ia_l[k]], ref_mem[ib_l[k]], pw_l[k]);
                if (noise) begin
                    start    = 1'($urandom);
                    pe_valid = 1'($urandom);
                    pe_fft_a = $urandom;
                    pe_fft_b = $urandom;
                end
                @(negedge clk);
            end
            start    = 1'b0;
            pe_valid = 1'b0;

            if (mode == 1 && s == 1) begin
                for (int c = 0; c < int'(TMO); c++) begin
                    chk("tmo_wait_done", done, 0);
                    chk("tmo_wait_busy", busy, 1);
                    @(negedge clk);
                end
                chk("tmo_done", done, 1);
                chk("tmo_err", err, 1);
                chk("tmo_busy", busy, 0);
                @(negedge clk);
                chk("tmo_done_pulse", done, 0);
                chk("tmo_err_hold", err, 1);
                return;
            end

            for (int c = 0; c < lat - 8; c++) begin
                chk("coll_ab_valid", pe_ab_valid, 0);
                chk("coll_pe_a_zero", pe_a, 0);
                chk("coll_pe_power_zero", 32'(pe_power), 0);
                chk("coll_pe_rst", pe_rst, 0);
                chk("coll_done", done, 0);
                if (mode == 2 && s == 2 && c == 1) begin
                    rst = 1'b0;
                    #1;
                    chk("abort_busy", busy, 0);
                    chk("abort_pe_rst", pe_rst, 1);
                    chk("abort_pe_b", pe_b, 0);
                    chk("abort_done", done, 0);
                    @(negedge clk);
                    chk("abort_hold_pe_rst", pe_rst, 1);
                    chk("abort_hold_done", done, 0);
                    rst = 1'b1;
                    @(negedge clk);
                    chk("abort_rel_done", done, 0);
                    chk("abort_rel_pe_rst", pe_rst, 0);
                    chk("abort_rel_busy", busy, 0);
                    return;
                end
                @(negedge clk);
            end
            for (int k = 0; k < 8; k++) begin
                pe_valid = 1'b1;
                pe_fft_a = ra[k];
                pe_fft_b = rb[k];
                @(negedge clk);
            end
            pe_valid = 1'b0;
            pe_fft_a = $urandom;
            pe_fft_b = $urandom;
            for (int k = 0; k < 8; k++) begin
                ref_mem[ia_l[k]] = ra[k];
                ref_mem[ib_l[k]] = rb[k];
            end
            chk("next_busy", busy, 1);
            chk("next_ab_valid", pe_ab_valid, 0);
            chk("next_pe_rst", pe_rst, 0);
            @(negedge clk);
        end

        for (int i = 0; i < 16; i++) begin
            chk("dump_valid", out_valid, 1);
            chk("dump_index", 32'(out_index), 32'(i));
            chk($sformatf("dump_data_%0d", i), out_data, ref_mem[bitrev(i)]);
            if (!mix) chk("dump_bitrev", out_data, 32'(bitrev(i)));
            chk("dump_done_low", done, 0);
            @(negedge clk);
        end
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_out_valid", out_valid, 0);
        chk("end_err", err, 0);
        chk("pe_rst_pulses", 32'(pe_rst_pulses), 4);
        @(negedge clk);
        chk("end_done_pulse", done, 0);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        pe_valid = 1'b0;
        pe_fft_a = '0;
        pe_fft_b = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_pe_rst", pe_rst, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ab_valid", pe_ab_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_pe_rst", pe_rst, 0);
        chk("idle_busy", busy, 0);

        run(8, 1'b0, 1'b0, 1'b0, 0);
        run(8 + int'($urandom_range(0, 3)), 1'b0, 1'b1, 1'b0, 0);
        run(9, 1'b1, 1'b1, 1'b1, 0);
        run(8, 1'b1, 1'b0, 1'b0, 0);
        run(8 + int'(TMO) - 1, 1'b0, 1'b1, 1'b0, 0);
        run(8, 1'b0, 1'b1, 1'b0, 1);
        @(negedge clk);
        chk("idle_err_kept", err, 1);
        run(10, 1'b0, 1'b1, 1'b0, 0);
        run(12, 1'b0, 1'b1, 1'b0, 2);
        run(8 + int'($urandom_range(0, 5)), 1'b0, 1'b1, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
